// File: rtl/tx_serializer_arbiter.sv
// Round-robin arbiter feeding one TX serializer: accept a word, pulse load,
// wait for completion (with watchdog), then hold an inter-word gap.
module tx_serializer_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 2*WIDTH+4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       ser_load,
  output logic [WIDTH-1:0]           ser_data,
  input  logic                       ser_done,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy,
  output logic                       timeout_err,
  input  logic                       err_clr
);
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int MAX_CNT = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0]         state;
  logic [ID_W-1:0]    last_grant;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    win_id;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic [WIDTH-1:0]   win_data;
  logic               wait_exit;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
    grant    = found ? (NUM_REQ'(1) << win_id) : '0;
    win_data = req_data[int'(win_id)*WIDTH +: WIDTH];
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign ser_load  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign wait_exit = ser_done || (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ser_data    <= '0;
      active_id   <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            ser_data   <= win_data;
            active_id  <= win_id;
            last_grant <= win_id;
            state      <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (wait_exit) begin
            cnt   <= '0;
            state <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) state <= IDLE;
          else                 cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      // A completion in the final watchdog cycle wins over the timeout.
      if (state == WAIT && !ser_done && cnt == TO_LAST) timeout_err <= 1'b1;
      else if (err_clr)                                 timeout_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tx_serializer_arbiter.sv
// Directed bench for tx_serializer_arbiter; a second instance covers GAP_CYCLES=0.
module tb_tx_serializer_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        ser_done;
  logic        err_clr;

  logic [3:0]  req_ready,  b_req_ready;
  logic        ser_load,   b_ser_load;
  logic [7:0]  ser_data,   b_ser_data;
  logic [1:0]  active_id,  b_active_id;
  logic        busy,       b_busy;
  logic        timeout_err, b_timeout_err;

  int errors = 0;
  int checks = 0;

  tx_serializer_arbiter #(.WIDTH(8), .NUM_REQ(4), .GAP_CYCLES(1), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_load(ser_load), .ser_data(ser_data),
    .ser_done(ser_done), .active_id(active_id), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  tx_serializer_arbiter #(.WIDTH(8), .NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT(20)) dut_b2b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(b_req_ready), .ser_load(b_ser_load), .ser_data(b_ser_data),
    .ser_done(ser_done), .active_id(b_active_id), .busy(b_busy),
    .timeout_err(b_timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    req_valid = '0; req_data = '0; ser_done = 1'b0; err_clr = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset;
    req_valid = '0; req_data = '0; ser_done = 1'b0; err_clr = 1'b0;
    rst = 1'b0;
    #3;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (ser_load !== 1'b0)    begin errors++; $display("FAIL reset_load: got %0b exp 0", ser_load); end
    checks++; if (ser_data !== 8'h00)   begin errors++; $display("FAIL reset_data: got %0h exp 00", ser_data); end
    checks++; if (active_id !== 2'd0)   begin errors++; $display("FAIL reset_id: got %0d exp 0", active_id); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", timeout_err); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single;
    int nbusy;
    int extra_loads;
    apply_reset();
    req_data  = 32'h0000_00A5;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (ser_load !== 1'b1)  begin errors++; $display("FAIL single_load: got %0b exp 1", ser_load); end
    checks++; if (ser_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h exp a5", ser_data); end
    checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d exp 0", active_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_load: got %b exp 0000", req_ready); end
    nbusy = 1;
    extra_loads = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      ser_done = 1'b0;
      if (!busy) break;
      nbusy++;
      if (ser_load) extra_loads++;
      if (c == 9) ser_done = 1'b1;
    end
    checks++; if (nbusy !== 11)      begin errors++; $display("FAIL single_busy_len: got %0d exp 11", nbusy); end
    checks++; if (extra_loads !== 0) begin errors++; $display("FAIL single_load_len: got %0d extra exp 0", extra_loads); end
    checks++; if (ser_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %0h exp a5", ser_data); end
  endtask

  task automatic test_fairness;
    logic [1:0] exp_id  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] exp_dat [8] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10, 8'h21, 8'h32, 8'h43};
    apply_reset();
    req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = 4'b1111;
    for (int w = 0; w < 8; w++) begin
      for (int t = 0; t < 10 && !ser_load; t++) step();
      checks++; if (ser_load !== 1'b1) begin errors++; $display("FAIL fair_load_w%0d: got %0b exp 1", w, ser_load); end
      checks++; if (active_id !== exp_id[w]) begin errors++; $display("FAIL fair_id_w%0d: got %0d exp %0d", w, active_id, exp_id[w]); end
      checks++; if (ser_data !== exp_dat[w]) begin errors++; $display("FAIL fair_data_w%0d: got %0h exp %0h", w, ser_data, exp_dat[w]); end
      step();
      ser_done = 1'b1;
      step();
      ser_done = 1'b0;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_watchdog;
    apply_reset();
    req_data  = 32'h0000_005A;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    checks++; if (ser_load !== 1'b1) begin errors++; $display("FAIL wd_load: got %0b exp 1", ser_load); end
    repeat (20) step();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_early: got %0b exp 0", timeout_err); end
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL wd_wait_busy: got %0b exp 1", busy); end
    err_clr = 1'b1;
    step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_set_prio: got %0b exp 1", timeout_err); end
    step();
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_clear: got %0b exp 0", timeout_err); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL wd_idle: got %0b exp 0", busy); end
    // done arriving in the last watchdog cycle counts as completion
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    repeat (20) step();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_done_tie: got %0b exp 0", timeout_err); end
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL wd_tie_gap: got %0b exp 1", busy); end
    step();
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL wd_tie_idle: got %0b exp 0", busy); end
  endtask

  task automatic test_spurious_done;
    apply_reset();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_idle: got %0b exp 0", busy); end
    req_data  = 32'h0000_0077;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    ser_done  = 1'b1;
    step();
    ser_done  = 1'b0;
    checks++; if (busy !== 1'b1 || ser_load !== 1'b0) begin errors++; $display("FAIL spur_load: got busy=%0b load=%0b exp busy=1 load=0", busy, ser_load); end
    repeat (3) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL spur_still_wait: got %0b exp 1", busy); end
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_finish: got %0b exp 0", busy); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    req_data  = {8'h00, 8'h00, 8'hB2, 8'hB1};
    req_valid = 4'b0011;
    step();
    checks++; if (b_ser_load !== 1'b1 || b_active_id !== 2'd0) begin errors++; $display("FAIL b2b_first: got load=%0b id=%0d exp load=1 id=0", b_ser_load, b_active_id); end
    step();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    checks++; if (b_busy !== 1'b0)         begin errors++; $display("FAIL b2b_idle: got %0b exp 0", b_busy); end
    checks++; if (b_req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_ready: got %b exp 0010", b_req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (b_ser_load !== 1'b1)    begin errors++; $display("FAIL b2b_second_load: got %0b exp 1", b_ser_load); end
    checks++; if (b_active_id !== 2'd1)   begin errors++; $display("FAIL b2b_second_id: got %0d exp 1", b_active_id); end
    checks++; if (b_ser_data !== 8'hB2)   begin errors++; $display("FAIL b2b_second_data: got %0h exp b2", b_ser_data); end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    req_data  = {8'h00, 8'h00, 8'hC1, 8'hC0};
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    checks++; if (active_id !== 2'd1) begin errors++; $display("FAIL mid_pre_id: got %0d exp 1", active_id); end
    step();
    step();
    #2;
    rst       = 1'b0;
    req_valid = 4'b0011;
    #1;
    checks++; if (busy !== 1'b0 || ser_load !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: got busy=%0b load=%0b exp 0 0", busy, ser_load); end
    checks++; if (ser_data !== 8'h00 || active_id !== 2'd0) begin errors++; $display("FAIL mid_rst_data: got data=%0h id=%0d exp 00 0", ser_data, active_id); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rst_ready: got %b exp 0001", req_ready); end
    step();
    rst = 1'b1;
    step();
    req_valid = 4'b0000;
    checks++; if (ser_load !== 1'b1 || active_id !== 2'd0) begin errors++; $display("FAIL mid_after_id: got load=%0b id=%0d exp 1 0", ser_load, active_id); end
    checks++; if (ser_data !== 8'hC0) begin errors++; $display("FAIL mid_after_data: got %0h exp c0", ser_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_watchdog();
    test_spurious_done();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
